// File: rtl/ofm_accum_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ofm_accum_ctrl_if                                        |
// | Description : Drain stream from the OFM accumulator to the OFM writer. |
// |               master = accumulator (drives data), slave = writer.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface ofm_accum_ctrl_if #(
    parameter int LANES    = 4,
    parameter int ACC_W    = 24,
    parameter int TILE_LEN = 16
);
    localparam int IDX_W = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;

    logic                   ofm_valid;
    logic                   ofm_ready;
    logic [LANES*ACC_W-1:0] ofm_data;
    logic [IDX_W-1:0]       ofm_idx;

    modport master (output ofm_valid, output ofm_data, output ofm_idx, input ofm_ready);
    modport slave  (input ofm_valid, input ofm_data, input ofm_idx, output ofm_ready);
endinterface
`default_nettype wire

// File: rtl/ofm_accum_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ofm_accum_ctrl                                           |
// | Description : Accumulates PE-array partial sums across input-channel   |
// |               passes into a TILE_LEN-entry buffer, then drains the     |
// |               finished tile over a valid/ready stream.                 |
// | Option      : define OFM_RELU_EN to clamp negative drained lanes to 0. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module ofm_accum_ctrl #(
    parameter int LANES    = 4,
    parameter int PSUM_W   = 16,
    parameter int ACC_W    = 24,
    parameter int TILE_LEN = 16
) (
    input  wire                     clk,
    input  wire                     rst,
    input  wire                     stall,
    input  wire                     start_conv,
    input  wire                     p_valid,
    input  wire                     last_chanel,
    input  wire                     end_conv,
    input  wire [LANES*PSUM_W-1:0]  psum_in,
    output logic                    start_again,
    ofm_accum_ctrl_if.master        ofm,
    output logic [15:0]             ofm_tile,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int IDX_W = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [LANES*ACC_W-1:0] buffer [TILE_LEN];
    logic [IDX_W-1:0]       beat_cnt;
    logic                   pass_last;
    logic                   first_pass;
    logic                   end_pend;

    logic                   beat;
    logic                   xfer;
    logic                   clr_idle;
    logic                   use_first;
    logic                   end_live;
    logic                   pass_last_eff;
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       rd_idx;
    logic [LANES*ACC_W-1:0] wr_old;
    logic [LANES*ACC_W-1:0] wr_data;
    logic [LANES*ACC_W-1:0] rd_raw;
    logic [LANES*ACC_W-1:0] rd_out;

    logic                   wr_en;
    logic                   last_beat;
    logic                   load_drain;
    logic                   pass_end;
    logic                   drain_end;
    logic                   more_drain;
    logic                   fire_done;
    logic                   err_set;

    // A beat or a stream transfer only exists in a non-stalled cycle.
    assign beat      = p_valid & ~stall;
    assign xfer      = ofm.ofm_valid & ofm.ofm_ready & ~stall;

    // start_conv in IDLE restarts the convolution; the beat arriving in the
    // same cycle must already see first_pass set.
    assign clr_idle  = start_conv & (state == IDLE);
    assign use_first = first_pass | clr_idle;

    // A stale pending end_conv is dropped by start_conv, a fresh one is not.
    assign end_live  = (end_pend & ~clr_idle) | end_conv;

    // The opening beat in IDLE always lands in entry 0 and decides pass_last.
    assign wr_idx        = (state == IDLE) ? '0 : beat_cnt;
    assign pass_last_eff = (state == IDLE) ? last_chanel : pass_last;
    assign wr_old        = buffer[wr_idx];

    // Next drain entry; forward the entry being written this cycle so the
    // first drained word is correct even when it is also the last written.
    assign rd_idx = load_drain ? '0 : (ofm.ofm_idx + IDX_W'(1));
    assign rd_raw = (wr_en && (wr_idx == rd_idx)) ? wr_data : buffer[rd_idx];

    assign busy = (state != IDLE);

    // Per-lane sign extension, accumulate (wrapping) and optional ReLU.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [PSUM_W-1:0] ps;
        logic signed [ACC_W-1:0]  ext;
        logic signed [ACC_W-1:0]  old;
        logic        [ACC_W-1:0]  nxt;

        assign ps  = psum_in[l*PSUM_W +: PSUM_W];
        assign ext = ACC_W'(ps);
        assign old = wr_old[l*ACC_W +: ACC_W];
        assign wr_data[l*ACC_W +: ACC_W] = use_first ? ext : (old + ext);
        assign nxt = rd_raw[l*ACC_W +: ACC_W];
`ifdef OFM_RELU_EN
        assign rd_out[l*ACC_W +: ACC_W] = nxt[ACC_W-1] ? '0 : nxt;
`else
        assign rd_out[l*ACC_W +: ACC_W] = nxt;
`endif
    end

    // FSM state register; a stalled cycle freezes the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (!stall) begin
            state <= state_nxt;
        end
    end

    // FSM next-state and per-cycle control strobes.
    always_comb begin
        state_nxt  = state;
        wr_en      = 1'b0;
        last_beat  = 1'b0;
        load_drain = 1'b0;
        pass_end   = 1'b0;
        drain_end  = 1'b0;
        more_drain = 1'b0;
        fire_done  = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    wr_en     = 1'b1;
                    last_beat = (wr_idx == LAST_IDX);
                    state_nxt = ACCUM;
                end else if (use_first && end_live) begin
                    fire_done = 1'b1;
                end
            end
            ACCUM: begin
                if (beat) begin
                    wr_en     = 1'b1;
                    last_beat = (wr_idx == LAST_IDX);
                end
            end
            DRAIN: begin
                err_set = beat;
                if (xfer) begin
                    if (ofm.ofm_idx == LAST_IDX) begin
                        drain_end = 1'b1;
                        state_nxt = end_live ? DONE : IDLE;
                    end else begin
                        more_drain = 1'b1;
                    end
                end
            end
            DONE: begin
                err_set   = beat;
                fire_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Closing beat of a pass: drain a finished tile or hand back for more.
        if (last_beat) begin
            if (pass_last_eff) begin
                load_drain = 1'b1;
                state_nxt  = DRAIN;
            end else begin
                pass_end   = 1'b1;
                state_nxt  = IDLE;
            end
        end
    end

    // Pass bookkeeping, status flags and handshake pulses back to the PE side.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt    <= '0;
            pass_last   <= 1'b0;
            first_pass  <= 1'b1;
            end_pend    <= 1'b0;
            start_again <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ofm_tile    <= 16'd0;
        end else if (!stall) begin
            if (wr_en) begin
                beat_cnt <= last_beat ? '0 : (wr_idx + IDX_W'(1));
            end
            if ((state == IDLE) && wr_en) begin
                pass_last <= last_chanel;
            end
            if (clr_idle)  first_pass <= 1'b1;
            if (pass_end)  first_pass <= 1'b0;
            if (drain_end) first_pass <= 1'b1;

            start_again <= pass_end | (drain_end & ~end_live);
            done        <= fire_done;

            if (clr_idle)  end_pend <= 1'b0;
            if (end_conv)  end_pend <= 1'b1;
            if (fire_done) end_pend <= 1'b0;

            if (start_conv) err <= 1'b0;
            if (err_set)    err <= 1'b1;

            if (clr_idle) begin
                ofm_tile <= 16'd0;
            end else if (drain_end) begin
                ofm_tile <= ofm_tile + 16'd1;
            end
        end
    end

    // Drain stream registers; data and index hold until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ofm.ofm_valid <= 1'b0;
            ofm.ofm_idx   <= '0;
            ofm.ofm_data  <= '0;
        end else if (!stall) begin
            if (load_drain) begin
                ofm.ofm_valid <= 1'b1;
                ofm.ofm_idx   <= '0;
                ofm.ofm_data  <= rd_out;
            end else if (more_drain) begin
                ofm.ofm_idx   <= rd_idx;
                ofm.ofm_data  <= rd_out;
            end else if (drain_end) begin
                ofm.ofm_valid <= 1'b0;
            end
        end
    end

    // Accumulator storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[wr_idx] <= wr_data;
        end
    end
endmodule
`default_nettype wire
